// File: rtl/library_mem_arbiter.sv
// library_mem_arbiter: single-port coordinate-library SRAM owner merging store writes with a page-scan read engine
// Ports:
//   i_clk, i_rst_n                  clock, asynchronous active-low reset
//   i_wr_valid/i_wr_addr/i_wr_data  library-store write stream ({page,idx}, {x,y}), never stalled
//   i_page_clr/i_clr_page           zero the fill length of one page
//   i_scan_start/i_scan_page        start streaming the valid entries of a page
//   i_scan_abort                    terminate the scan, drop in-flight data
//   o_busy, o_scan_err, o_scan_done scan engine status pulses
//   o_rd_valid/o_rd_x/o_rd_y/o_rd_last  scanned {x,y} stream to the matcher
//   o_mem_*/i_mem_rdata             SRAM port, read data one cycle after a read enable
// Optional: define LIB_ARB_STATS_EN to add o_stall_cnt (SCAN cycles stalled by a write).
module library_mem_arbiter #(
  parameter int PAGES  = 26,
  parameter int PAGE_W = 5,
  parameter int IDX_W  = 11,
  parameter int DATA_W = 10
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_wr_valid,
  input  logic [PAGE_W+IDX_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0]       i_wr_data,
  input  logic                    i_page_clr,
  input  logic [PAGE_W-1:0]       i_clr_page,
  input  logic                    i_scan_start,
  input  logic [PAGE_W-1:0]       i_scan_page,
  input  logic                    i_scan_abort,
  output logic                    o_busy,
  output logic                    o_scan_err,
  output logic                    o_rd_valid,
  output logic [4:0]              o_rd_x,
  output logic [4:0]              o_rd_y,
  output logic                    o_rd_last,
  output logic                    o_scan_done,
  output logic                    o_mem_cen,
  output logic                    o_mem_wen,
  output logic [PAGE_W+IDX_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0]       o_mem_wdata,
`ifdef LIB_ARB_STATS_EN
  output logic [15:0]             o_stall_cnt,
`endif
  input  logic [DATA_W-1:0]       i_mem_rdata
);
  localparam int AW = PAGE_W + IDX_W;
  localparam logic [PAGE_W-1:0] LIM = PAGE_W'(PAGES);
  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;
  state_t state;
  logic [IDX_W:0] len [PAGES];
  logic [IDX_W:0] len_nxt [PAGES];
  logic [IDX_W:0] len_s;
  logic [PAGE_W-1:0] page_s;
  logic [IDX_W-1:0] idx;
  logic [PAGE_W-1:0] wr_page;
  logic [IDX_W:0] wr_len;
  logic vld, last, done, err, pend, rd_iss, at_last, accept;
  assign wr_page = i_wr_addr[AW-1:IDX_W];
  assign wr_len = {1'b0, i_wr_addr[IDX_W-1:0]} + 1'b1;
  // Clear is applied before the write so a same-cycle write to the cleared page wins.
  always_comb begin
    len_nxt = len;
    if (i_page_clr && i_clr_page < LIM) len_nxt[i_clr_page] = '0;
    if (i_wr_valid && wr_page < LIM && len_nxt[wr_page] < wr_len) len_nxt[wr_page] = wr_len;
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) for (int i = 0; i < PAGES; i++) len[i] <= '0;
    else len <= len_nxt;
  assign pend = state == SCAN && len_s != '0 && !i_scan_abort;
  assign rd_iss = pend && !i_wr_valid;
  assign at_last = {1'b0, idx} == len_s - 1'b1;
  assign accept = state == IDLE && i_scan_start && !i_scan_abort && i_scan_page < LIM;
  // Writes own the SRAM port outright; the scan read simply waits.
  assign o_mem_cen = i_wr_valid | rd_iss;
  assign o_mem_wen = i_wr_valid;
  assign o_mem_addr = i_wr_valid ? i_wr_addr : rd_iss ? {page_s, idx} : '0;
  assign o_mem_wdata = i_wr_valid ? i_wr_data : '0;
  // Abort masks read data already in flight and the done pulse in the same cycle.
  assign o_busy = state != IDLE;
  assign o_scan_err = err;
  assign o_rd_valid = vld & ~i_scan_abort;
  assign o_rd_last = last & ~i_scan_abort;
  assign o_scan_done = done & ~i_scan_abort;
  assign o_rd_x = o_rd_valid ? i_mem_rdata[9:5] : '0;
  assign o_rd_y = o_rd_valid ? i_mem_rdata[4:0] : '0;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state <= IDLE;
      len_s <= '0;
      page_s <= '0;
      idx <= '0;
      vld <= 1'b0;
      last <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      vld <= rd_iss;
      last <= rd_iss && at_last;
      done <= 1'b0;
      err <= 1'b0;
      if (i_scan_abort) state <= IDLE;
      else
        case (state)
          IDLE: begin
            err <= i_scan_start && !accept;
            if (accept) begin
              state <= SCAN;
              len_s <= len_nxt[i_scan_page];
              page_s <= i_scan_page;
              idx <= '0;
            end
          end
          SCAN:
            if (len_s == '0) begin
              done <= 1'b1;
              state <= IDLE;
            end else if (rd_iss) begin
              idx <= idx + 1'b1;
              if (at_last) begin
                done <= 1'b1;
                state <= DRAIN;
              end
            end
          DRAIN: state <= IDLE;
          default: state <= IDLE;
        endcase
    end
`ifdef LIB_ARB_STATS_EN
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) o_stall_cnt <= '0;
    else if (accept) o_stall_cnt <= '0;
    else if (pend && i_wr_valid && o_stall_cnt != 16'hFFFF) o_stall_cnt <= o_stall_cnt + 1'b1;
`endif
endmodule

// File: tb/tb_library_mem_arbiter.sv
// tb_library_mem_arbiter: scoreboard bench for library_mem_arbiter with an SRAM model
module tb_library_mem_arbiter;
  logic i_clk = 1'b0, i_rst_n = 1'b0;
  logic i_wr_valid = 1'b0, i_page_clr = 1'b0, i_scan_start = 1'b0, i_scan_abort = 1'b0;
  logic [15:0] i_wr_addr = '0;
  logic [9:0] i_wr_data = '0, i_mem_rdata = '0;
  logic [4:0] i_clr_page = '0, i_scan_page = '0;
  logic o_busy, o_scan_err, o_rd_valid, o_rd_last, o_scan_done, o_mem_cen, o_mem_wen;
  logic [4:0] o_rd_x, o_rd_y;
  logic [15:0] o_mem_addr;
  logic [9:0] o_mem_wdata;
`ifdef LIB_ARB_STATS_EN
  logic [15:0] o_stall_cnt;
`endif
  int checks = 0, failures = 0;
  logic [13:0] exp_q[$];
  logic [13:0] obs, e;
  logic [9:0] mem [65536];
  library_mem_arbiter dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_wr_valid(i_wr_valid), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
    .i_page_clr(i_page_clr), .i_clr_page(i_clr_page),
    .i_scan_start(i_scan_start), .i_scan_page(i_scan_page), .i_scan_abort(i_scan_abort),
    .o_busy(o_busy), .o_scan_err(o_scan_err), .o_rd_valid(o_rd_valid),
    .o_rd_x(o_rd_x), .o_rd_y(o_rd_y), .o_rd_last(o_rd_last), .o_scan_done(o_scan_done),
    .o_mem_cen(o_mem_cen), .o_mem_wen(o_mem_wen), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata),
`ifdef LIB_ARB_STATS_EN
    .o_stall_cnt(o_stall_cnt),
`endif
    .i_mem_rdata(i_mem_rdata)
  );
  always #5 i_clk = ~i_clk;
  always @(posedge i_clk)
    if (o_mem_cen) begin
      if (o_mem_wen) mem[o_mem_addr] <= o_mem_wdata;
      else i_mem_rdata <= mem[o_mem_addr];
    end
  function automatic logic [9:0] dat(int p, int i);
    return {5'(p + i), 5'(3 * i + 1)};
  endfunction
  function automatic logic [13:0] ev(logic v, logic [9:0] d, logic l, logic dn, logic er);
    return {v, v ? d : 10'd0, l, dn, er};
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask
  always @(negedge i_clk)
    if (i_rst_n && (o_rd_valid || o_scan_done || o_scan_err)) begin
      obs = {o_rd_valid, o_rd_x, o_rd_y, o_rd_last, o_scan_done, o_scan_err};
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_event actual=%0h required=none", obs);
      end else begin
        e = exp_q.pop_front();
        chk("event", 32'(obs), 32'(e));
      end
    end
  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask
  task automatic wr(int p, int i, logic clr);
    i_wr_valid = 1'b1;
    i_wr_addr = {5'(p), 11'(i)};
    i_wr_data = dat(p, i);
    i_page_clr = clr;
    i_clr_page = 5'(p);
    tick;
    i_wr_valid = 1'b0;
    i_page_clr = 1'b0;
  endtask
  task automatic start(int p);
    i_scan_start = 1'b1;
    i_scan_page = 5'(p);
    tick;
    i_scan_start = 1'b0;
  endtask
  task automatic wait_idle(string name);
    int n = 0;
    while (o_busy && n < 100) begin
      tick;
      n++;
    end
    chk({name, "_timeout"}, 32'(n < 100), 1);
    tick;
    chk({name, "_drained"}, exp_q.size(), 0);
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
  initial begin
    #12;
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_rd_valid", 32'(o_rd_valid), 0);
    chk("rst_done", 32'(o_scan_done), 0);
    chk("rst_err", 32'(o_scan_err), 0);
    chk("rst_cen", 32'(o_mem_cen), 0);
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    tick;
    // page 3, five entries
    for (int i = 0; i < 5; i++) wr(3, i, 1'b0);
    for (int i = 0; i < 5; i++) exp_q.push_back(ev(1'b1, dat(3, i), i == 4, i == 4, 1'b0));
    start(3);
    chk("scan3_busy", 32'(o_busy), 1);
    wait_idle("scan3");
    // empty page
    exp_q.push_back(ev(1'b0, 10'd0, 1'b0, 1'b1, 1'b0));
    start(7);
    chk("scan7_busy", 32'(o_busy), 1);
    wait_idle("scan7");
    // out-of-range page
    exp_q.push_back(ev(1'b0, 10'd0, 1'b0, 1'b0, 1'b1));
    start(26);
    chk("scan26_err", 32'(o_scan_err), 1);
    chk("scan26_busy", 32'(o_busy), 0);
    tick;
    chk("scan26_err_pulse", 32'(o_scan_err), 0);
    chk("scan26_busy2", 32'(o_busy), 0);
    wait_idle("scan26");
    // page 1 with two stalling writes
    for (int i = 0; i < 4; i++) wr(1, i, 1'b0);
    for (int i = 0; i < 4; i++) exp_q.push_back(ev(1'b1, dat(1, i), i == 3, i == 3, 1'b0));
    start(1);
    i_wr_valid = 1'b1;
    i_wr_addr = {5'd5, 11'd0};
    i_wr_data = dat(5, 0);
    #1;
    chk("arb_write_addr", 32'(o_mem_addr), 32'({5'd5, 11'd0}));
    chk("arb_write_wen", 32'(o_mem_wen), 1);
    i_wr_valid = 1'b0;
    wr(5, 0, 1'b0);
    wr(5, 1, 1'b0);
    wait_idle("scan1");
`ifdef LIB_ARB_STATS_EN
    chk("stall_cnt", 32'(o_stall_cnt), 2);
`endif
    // abort after second read issue of an 8-entry page
    for (int i = 0; i < 8; i++) wr(4, i, 1'b0);
    exp_q.push_back(ev(1'b1, dat(4, 0), 1'b0, 1'b0, 1'b0));
    start(4);
    tick;
    tick;
    i_scan_abort = 1'b1;
    tick;
    i_scan_abort = 1'b0;
    chk("abort_busy", 32'(o_busy), 0);
    tick;
    tick;
    chk("abort_drained", exp_q.size(), 0);
    // clear and write same page same cycle
    for (int i = 0; i < 9; i++) wr(2, i, 1'b0);
    wr(2, 9, 1'b1);
    for (int i = 0; i < 10; i++) exp_q.push_back(ev(1'b1, dat(2, i), i == 9, i == 9, 1'b0));
    start(2);
    wait_idle("scan2");
    i_page_clr = 1'b1;
    i_clr_page = 5'd2;
    tick;
    i_page_clr = 1'b0;
    exp_q.push_back(ev(1'b0, 10'd0, 1'b0, 1'b1, 1'b0));
    start(2);
    wait_idle("scan2_cleared");
    // write to an out-of-range page still reaches SRAM
    i_wr_valid = 1'b1;
    i_wr_addr = {5'd30, 11'd5};
    i_wr_data = 10'h2A5;
    #1;
    chk("hi_page_cen", 32'(o_mem_cen), 1);
    chk("hi_page_addr", 32'(o_mem_addr), 32'({5'd30, 11'd5}));
    chk("hi_page_wdata", 32'(o_mem_wdata), 32'h2A5);
    tick;
    i_wr_valid = 1'b0;
    // abort beats start in the same cycle
    i_scan_abort = 1'b1;
    start(3);
    i_scan_abort = 1'b0;
    chk("abort_start_busy", 32'(o_busy), 0);
    chk("abort_start_err", 32'(o_scan_err), 0);
    tick;
    chk("final_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
